// File: rtl/ppu_ctrl_pipe_if.sv
// Decode-to-pipe control interface: decode-side word, hazard inputs and per-stage unpacked controls.
// Master is the decode/datapath side; slave is the EX/MEM/WB control pipe.
interface ppu_ctrl_pipe_if #(
   parameter int CTRL_W = 22,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
);
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_valid;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              id_uses_rt;
   logic [REG_W-1:0]  id_dest;
   logic              flush;
   logic              mem_hold;
   logic              stall_if_id;
   logic [2:0]        ex_src_op;
   logic [3:0]        ex_alu_op;
   logic              ex_b_instr;
   logic              ex_ta_instr;
   logic              ex_uncond_jump;
   logic              ex_cond_uncond;
   logic [1:0]        mem_size;
   logic              mem_rw;
   logic              mem_se;
   logic              mem_enable;
   logic              mem_load;
   logic              wb_rf_enable;
   logic              wb_hi_en;
   logic              wb_lo_en;
   logic              wb_r31;
   logic              wb_dest_sel;
   logic [REG_W-1:0]  wb_dest;
   logic [CNT_W-1:0]  bubble_count;

   modport master (
      output id_ctrl, id_valid, id_rs, id_rt, id_uses_rt, id_dest, flush, mem_hold,
      input  stall_if_id, ex_src_op, ex_alu_op, ex_b_instr, ex_ta_instr, ex_uncond_jump,
             ex_cond_uncond, mem_size, mem_rw, mem_se, mem_enable, mem_load, wb_rf_enable,
             wb_hi_en, wb_lo_en, wb_r31, wb_dest_sel, wb_dest, bubble_count
   );

   modport slave (
      input  id_ctrl, id_valid, id_rs, id_rt, id_uses_rt, id_dest, flush, mem_hold,
      output stall_if_id, ex_src_op, ex_alu_op, ex_b_instr, ex_ta_instr, ex_uncond_jump,
             ex_cond_uncond, mem_size, mem_rw, mem_se, mem_enable, mem_load, wb_rf_enable,
             wb_hi_en, wb_lo_en, wb_r31, wb_dest_sel, wb_dest, bubble_count
   );
endinterface

// File: rtl/ppu_ctrl_pipe.sv
// EX/MEM/WB control-word pipe: 1 cycle per stage (EX 1, MEM 2, WB 3 after decode sample).
// No back-pressure except stall_if_id (load-use or mem_hold); mem_hold freezes every stage.
module ppu_ctrl_pipe #(
   parameter int CTRL_W = 22,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   ppu_ctrl_pipe_if.slave  bus
);
   typedef struct packed {
      logic              vld;
      logic [CTRL_W-1:0] ctrl;
      logic [REG_W-1:0]  dest;
   } stage_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic             hazard;

   always_comb begin
      hazard = ex_q.vld & ex_q.ctrl[10] & ex_q.ctrl[9] & (ex_q.dest != '0) & bus.id_valid &
               ((ex_q.dest == bus.id_rs) | (bus.id_uses_rt & (ex_q.dest == bus.id_rt)));
      ex_d         = ex_q;
      mem_d        = mem_q;
      wb_d         = wb_q;
      bubble_cnt_d = bubble_cnt_q;
      if (!bus.mem_hold) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         // flush and load-use both squash the decode slot; flush+hazard is still one bubble
         if (bus.flush | hazard) begin
            ex_d = '0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
         end else begin
            ex_d.vld  = bus.id_valid;
            ex_d.ctrl = bus.id_ctrl;
            ex_d.dest = bus.id_dest;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ex_q         <= ex_d;
         mem_q        <= mem_d;
         wb_q         <= wb_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.stall_if_id    = hazard | bus.mem_hold;

   assign bus.ex_src_op      = ex_q.ctrl[17:15] & {3{ex_q.vld}};
   assign bus.ex_alu_op      = ex_q.ctrl[14:11] & {4{ex_q.vld}};
   assign bus.ex_b_instr     = ex_q.ctrl[8]  & ex_q.vld;
   assign bus.ex_ta_instr    = ex_q.ctrl[7]  & ex_q.vld;
   assign bus.ex_uncond_jump = ex_q.ctrl[19] & ex_q.vld;
   assign bus.ex_cond_uncond = ex_q.ctrl[21] & ex_q.vld;

   assign bus.mem_size       = mem_q.ctrl[6:5] & {2{mem_q.vld}};
   assign bus.mem_rw         = mem_q.ctrl[4]  & mem_q.vld;
   assign bus.mem_se         = mem_q.ctrl[3]  & mem_q.vld;
   assign bus.mem_enable     = mem_q.ctrl[0]  & mem_q.vld;
   assign bus.mem_load       = mem_q.ctrl[10] & mem_q.vld;

   assign bus.wb_rf_enable   = wb_q.ctrl[9]  & wb_q.vld;
   assign bus.wb_hi_en       = wb_q.ctrl[2]  & wb_q.vld;
   assign bus.wb_lo_en       = wb_q.ctrl[1]  & wb_q.vld;
   assign bus.wb_r31         = wb_q.ctrl[20] & wb_q.vld;
   assign bus.wb_dest_sel    = wb_q.ctrl[18] & wb_q.vld;
   assign bus.wb_dest        = wb_q.dest & {REG_W{wb_q.vld}};

   assign bus.bubble_count   = bubble_cnt_q;

   // Each stage carries the whole word; fields not consumed at that stage are intentionally dropped.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^{ex_q.ctrl, mem_q.ctrl, mem_q.dest, wb_q.ctrl};
endmodule
